// File: rtl/dm_pkg.sv
// Shared types and defaults for the data-memory responder.
// Holds the FSM state encoding and the word-index width helper.
package dm_pkg;

  localparam int DM_DEPTH   = 1024;
  localparam int DM_LATENCY = 2;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } dm_state_e;

  function automatic int dm_idx_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/dm_ram.sv
// DEPTH x 32 single-port word array: synchronous byte-masked write, combinational read.
// The read port returns the pre-write word during a write cycle.
module dm_ram
  import dm_pkg::*;
#(
  parameter int DEPTH = DM_DEPTH
) (
  input  logic                         i_clk,
  input  logic                         i_we,
  input  logic [dm_idx_w(DEPTH)-1:0]   i_addr,
  input  logic [3:0]                   i_be,
  input  logic [31:0]                  i_wdata,
  output logic [31:0]                  o_rdata
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int i = 0; i < 4; i++) begin
        if (i_be[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dm_responder.sv
// Memory end of the core's load/store channel: one request at a time, fixed latency,
// byte-masked write returning the pre-write word; clears the array after every reset.
module dm_responder
  import dm_pkg::*;
#(
  parameter int DEPTH   = DM_DEPTH,
  parameter int LATENCY = DM_LATENCY
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic [3:0]  i_req_be,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  input  logic        i_resp_ready,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_err,
  output logic        o_init_done
);

  localparam int AW = dm_idx_w(DEPTH);

  dm_state_e     r_state, w_next;
  logic [AW-1:0] r_ptr;
  logic [3:0]    r_count;
  logic [31:0]   r_addr;
  logic [3:0]    r_be;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic          r_err;
  logic          r_init_done;

  logic [31:0]   w_idx;
  logic          w_in_range;
  logic          w_accept;
  logic          w_access;
  logic          w_ram_we;
  logic [AW-1:0] w_ram_addr;
  logic [3:0]    w_ram_be;
  logic [31:0]   w_ram_wdata;
  logic [31:0]   w_ram_rdata;

  // Full 30-bit word index so addresses beyond DEPTH never alias onto low words.
  assign w_idx      = r_addr >> 2;
  assign w_in_range = w_idx < 32'(DEPTH);
  assign w_accept   = i_req_valid && o_req_ready;
  assign w_access   = (r_state == ST_WAIT) && (r_count == 4'd0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_INIT;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    o_req_ready  = 1'b0;
    o_resp_valid = 1'b0;
    w_ram_we     = 1'b0;
    w_ram_addr   = w_idx[AW-1:0];
    w_ram_be     = r_be;
    w_ram_wdata  = r_wdata;
    case (r_state)
      ST_INIT: begin
        w_ram_we    = 1'b1;
        w_ram_addr  = r_ptr;
        w_ram_be    = 4'hF;
        w_ram_wdata = 32'h0;
        if (r_ptr == AW'(DEPTH - 1)) w_next = ST_IDLE;
      end
      ST_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) w_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (r_count == 4'd0) begin
          w_ram_we = w_in_range;
          w_next   = ST_RESP;
        end
      end
      ST_RESP: begin
        o_resp_valid = 1'b1;
        if (i_resp_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_INIT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr       <= '0;
      r_count     <= 4'd0;
      r_addr      <= 32'h0;
      r_be        <= 4'h0;
      r_wdata     <= 32'h0;
      r_rdata     <= 32'h0;
      r_err       <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      if (r_state == ST_INIT) begin
        r_ptr <= r_ptr + AW'(1);
        if (r_ptr == AW'(DEPTH - 1)) r_init_done <= 1'b1;
      end
      if (w_accept) begin
        r_addr  <= i_req_addr;
        r_be    <= i_req_be;
        r_wdata <= i_req_wdata;
        r_count <= 4'(LATENCY - 1);
      end else if ((r_state == ST_WAIT) && (r_count != 4'd0)) begin
        r_count <= r_count - 4'd1;
      end
      // Response captures the word as it stood before this edge's write.
      if (w_access) begin
        r_rdata <= w_in_range ? w_ram_rdata : 32'h0;
        r_err   <= !w_in_range;
      end
    end
  end

  dm_ram #(.DEPTH(DEPTH)) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_be    (w_ram_be),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  assign o_resp_rdata = r_rdata;
  assign o_resp_err   = r_err;
  assign o_init_done  = r_init_done;

endmodule

// File: tb/tb_dm_responder.sv
// Directed plus randomized bench for dm_responder against a word-array reference model.
module tb_dm_responder;

  localparam int DEPTH   = 1024;
  localparam int LATENCY = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        init_done;

  int checks = 0;
  int errors = 0;
  logic [31:0] mdl [DEPTH];

  dm_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_addr   (req_addr),
    .i_req_be     (req_be),
    .i_req_wdata  (req_wdata),
    .o_resp_valid (resp_valid),
    .i_resp_ready (resp_ready),
    .o_resp_rdata (resp_rdata),
    .o_resp_err   (resp_err),
    .o_init_done  (init_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
  endtask

  // Reset must already be released; counts cycles until the clear sweep reports done.
  task automatic wait_init(input string tag);
    int  n;
    bit  early_ready;
    n = 0;
    early_ready = 0;
    while (!init_done && n < 3000) begin
      step();
      n++;
      if (req_ready && !init_done) early_ready = 1;
    end
    req_valid = 1'b0;
    chk({tag, " init cycles"}, 32'(n), 32'(DEPTH));
    chk({tag, " ready during init"}, 32'(early_ready), 32'd0);
    chk({tag, " ready after init"}, 32'(req_ready), 32'd1);
  endtask

  // One full transaction; checks latency, response against the model, stability under backpressure.
  task automatic txn(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wdata,
                     input int hold, input bit early, output logic [31:0] rdata);
    int          n;
    longint      idx;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [31:0] held_rdata;
    logic        held_err;
    rdata = 32'hx;
    req_addr  = addr;
    req_be    = be;
    req_wdata = wdata;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      step();
      n++;
    end
    if (!req_ready) begin
      chk("req_ready timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    step();
    req_valid  = 1'b0;
    req_addr   = $urandom;
    req_be     = 4'($urandom);
    req_wdata  = $urandom;
    resp_ready = early;

    idx       = longint'(addr) / 4;
    exp_err   = (idx >= DEPTH);
    exp_rdata = exp_err ? 32'h0 : mdl[idx];
    if (!exp_err) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mdl[idx][8*b +: 8] = wdata[8*b +: 8];
    end

    n = 0;
    while (!resp_valid && n < 40) begin
      chk("req_ready while busy", 32'(req_ready), 32'd0);
      step();
      n++;
    end
    chk("latency", 32'(n), 32'(LATENCY));
    chk("resp_rdata", resp_rdata, exp_rdata);
    chk("resp_err", 32'(resp_err), 32'(exp_err));
    held_rdata = resp_rdata;
    held_err   = resp_err;
    rdata      = resp_rdata;
    if (!early) begin
      for (int h = 0; h < hold; h++) begin
        step();
        chk("hold resp_valid", 32'(resp_valid), 32'd1);
        chk("hold rdata", resp_rdata, held_rdata);
        chk("hold err", 32'(resp_err), 32'(held_err));
        chk("hold req_ready", 32'(req_ready), 32'd0);
      end
      resp_ready = 1'b1;
    end
    step();
    resp_ready = 1'b0;
    chk("resp_valid after take", 32'(resp_valid), 32'd0);
    chk("req_ready after take", 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    logic [3:0]  be;
    int          r;

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_addr   = 32'h0;
    req_be     = 4'h0;
    req_wdata  = 32'h0;
    resp_ready = 1'b0;
    clear_model();
    step();
    step();
    chk("rst req_ready", 32'(req_ready), 32'd0);
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rst rdata", resp_rdata, 32'h0);
    chk("rst err", 32'(resp_err), 32'd0);
    chk("rst init_done", 32'(init_done), 32'd0);

    // A write offered during the sweep must be ignored.
    rst_n     = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h40;
    req_be    = 4'hF;
    req_wdata = 32'hFFFF_FFFF;
    wait_init("first");

    txn(32'h0000_0FFC, 4'h0, 32'h0, 0, 0, rd);
    chk("read top word", rd, 32'h0);
    txn(32'h0000_0040, 4'h0, 32'h0, 0, 0, rd);
    chk("init write ignored", rd, 32'h0);

    txn(32'h10, 4'hF, 32'hDEAD_BEEF, 0, 0, rd);
    chk("write old value", rd, 32'h0);
    txn(32'h10, 4'h0, 32'h0, 0, 0, rd);
    chk("read full write", rd, 32'hDEAD_BEEF);
    txn(32'h10, 4'b0101, 32'h1122_3344, 0, 0, rd);
    txn(32'h10, 4'h0, 32'h0, 0, 0, rd);
    chk("merge 0101", rd, 32'hDE22_BE44);
    txn(32'h10, 4'b1000, 32'hAA00_0000, 0, 1, rd);
    txn(32'h13, 4'h0, 32'h0, 0, 0, rd);
    chk("merge 1000", rd, 32'hAA22_BE44);

    txn(32'h0000_1000, 4'h0, 32'h0, 0, 0, rd);
    chk("oor read data", rd, 32'h0);
    chk("oor err", 32'(resp_err), 32'd1);
    txn(32'h0000_1000, 4'hF, 32'h5555_AAAA, 0, 0, rd);
    txn(32'h8000_0000, 4'hF, 32'h5555_AAAA, 0, 0, rd);
    txn(32'h0, 4'h0, 32'h0, 0, 0, rd);
    chk("oor no alias", rd, 32'h0);

    txn(32'h10, 4'h0, 32'h0, 5, 0, rd);
    chk("backpressure read", rd, 32'hAA22_BE44);

    for (int t = 0; t < 60; t++) begin
      r = $urandom_range(0, 9);
      if (r == 0) a = $urandom | 32'h0000_1000;
      else        a = ($urandom_range(0, 31) << 2) | $urandom_range(0, 3);
      be = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      txn(a, be, $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)), rd);
    end

    // Reset while the write to 0x20 is still waiting.
    req_addr  = 32'h20;
    req_be    = 4'hF;
    req_wdata = 32'h1234_5678;
    req_valid = 1'b1;
    r = 0;
    while (!req_ready && r < 50) begin
      step();
      r++;
    end
    chk("pre-reset ready", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    chk("in wait", 32'(resp_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid rst req_ready", 32'(req_ready), 32'd0);
    chk("mid rst resp_valid", 32'(resp_valid), 32'd0);
    chk("mid rst rdata", resp_rdata, 32'h0);
    chk("mid rst err", 32'(resp_err), 32'd0);
    chk("mid rst init_done", 32'(init_done), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    clear_model();
    wait_init("second");
    txn(32'h20, 4'h0, 32'h0, 0, 0, rd);
    chk("dropped write", rd, 32'h0);
    txn(32'h10, 4'h0, 32'h0, 0, 0, rd);
    chk("cleared after reset", rd, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_responder.md
# dm_responder

Data-memory responder for the pipelined MIPS core: it is the memory end of the core's load/store request channel. It accepts one word/byte-enabled request at a time over a valid/ready handshake, holds it for a programmable latency, performs the read or byte-masked write, and returns a response over a second valid/ready handshake. After every reset it clears its storage with a hardware sweep before accepting traffic, so the system bench starts every run from all-zero data memory.

## Interface
- DEPTH, 1024, number of 32-bit words; power of two, at least 4
- LATENCY, 2, cycles from acceptance to response; 1..15
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  responder can accept
- req_addr  in  32  byte address; bits [1:0] ignored
- req_be  in  4  byte enables; 4'b0000 = read, nonzero = write
- req_wdata  in  32  write data, byte lanes per req_be
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes response
- resp_rdata  out  32  read data (reads); word value before the write (writes)
- resp_err  out  1  address out of range
- init_done  out  1  clear sweep finished

## Operation
- States: INIT, IDLE, WAIT, RESP.
- INIT: writes 0 to word index ptr, ptr++ each cycle; after index DEPTH-1 -> IDLE, init_done=1 (stays 1 until next reset).
- IDLE: req_ready=1. Accept on req_valid&&req_ready: latch addr/be/wdata, load count=LATENCY-1, -> WAIT (LATENCY=1 goes straight to the access edge, see Timing).
- WAIT: count-- each cycle; at count==0 perform the access and -> RESP.
- Access: word index = req_addr[31:2]; in range iff index < DEPTH. In range: resp_rdata = stored word (pre-write); for each set be[i], byte i replaced by wdata byte i. Out of range: no write, resp_rdata=0, resp_err=1.
- RESP: resp_valid=1, outputs stable until resp_valid&&resp_ready -> IDLE.
- One transaction outstanding; no pipelining of requests.

## Timing
- Reset (async assert): state=INIT, ptr=0, req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, init_done=0. Deassertion takes effect at the next rising edge.
- INIT lasts exactly DEPTH cycles; req_ready is 0 throughout, requests ignored.
- Acceptance at edge k -> resp_valid rises at edge k+LATENCY. Memory is updated at that same edge.
- Completion at edge m (resp_valid&&resp_ready) -> req_ready=1 from edge m; next acceptance earliest edge m+1. Minimum request spacing = LATENCY+1 cycles.
- resp_ready held high before resp_valid: no effect until RESP.
- req_valid may drop before acceptance with no effect; req_* sampled only at the acceptance edge.
- Reset mid-WAIT: access never happens (write dropped); mid-RESP: write already done, response lost; INIT re-clears everything anyway.
- Byte-enable merge and range check are purely combinational on latched fields; no partial-word read-modify-write across cycles.

## Structure
- Package dm_pkg: state enum (INIT, IDLE, WAIT, RESP), DEPTH/LATENCY defaults, word-index helper width = clog2(DEPTH).
- Sub-module dm_ram: DEPTH×32 single-port array, synchronous write with 4-bit byte mask, combinational read; responder owns FSM, counter, latches, clear sweep (drives dm_ram with be=4'b1111, data 0 during INIT).

## Test plan
- Reset release, DEPTH=1024: req_ready=0 and init_done=0 for 1024 cycles, then both 1; read of addr 0x0000_0FFC returns 0, resp_err=0.
- Write addr 0x10, be=4'b1111, wdata=0xDEAD_BEEF, LATENCY=2: resp_valid at acceptance+2, resp_rdata=0; read 0x10 returns 0xDEAD_BEEF.
- Byte merge: after above, write 0x10 be=4'b0101 wdata=0x1122_3344 -> read returns 0xDE22_BE44; write with be=4'b1000 wdata=0xAA00_0000 -> 0xAA22_BE44.
- Out of range: read 0x0000_1000 (index 1024) -> resp_err=1, resp_rdata=0; write there leaves all words unchanged.
- Backpressure: hold resp_ready=0 for 5 cycles after resp_valid -> outputs stable, req_ready=0; raise resp_ready -> req_ready=1 next cycle, new request accepted the cycle after.
- Reset asserted during WAIT of write 0x20 <- 0x1234_5678: outputs zero immediately; after INIT, read 0x20 returns 0.
